dmem_arbiter: RTL and testbench

Two-port request/acknowledge arbiter that shares the single-port, byte-addressed, big-endian `data_memory` (128 bytes, combinational read, negedge write) between two word-access requesters, e.g. the load/store stage (port 0) and a debug/loader port (port 1). It uses round-robin arbitration and registers each transaction into a fixed three-cycle access. It rejects misaligned and out-of-range accesses without touching memory, and returns registered read data with a one-cycle acknowledge.

---
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between dmem_arbiter, its two word requesters and data_memory.
// The arbiter takes the slave view; requesters and memory together take the master view.
interface dmem_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic        ack0;
   logic        ack1;
   logic        err0;
   logic        err1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;
   logic        busy;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_out;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
      output ack0, ack1, err0, err1, rdata0, rdata1, busy,
             mem_address, mem_write_data, mem_read, mem_write
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
      input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
             mem_address, mem_write_data, mem_read, mem_write
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port big-endian byte memory.
// Every output is a register; the memory strobes exist only during the one ACCESS cycle.
module dmem_arbiter #(
   parameter int unsigned DEPTH = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);

   // Word-aligned and fully inside memory; compared unsigned on 32 bits so it cannot wrap.
   function automatic logic addr_legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= LAST_WORD);
   endfunction

   state_t      state_r, state_s;
   logic        last_r, last_s;
   logic [1:0]  done_r, done_s;
   logic        gnt_r, gnt_s;
   logic        we_r, we_s;
   logic [1:0]  ack_r, ack_s;
   logic [1:0]  err_r, err_s;
   logic [31:0] rdata0_r, rdata0_s;
   logic [31:0] rdata1_r, rdata1_s;
   logic        busy_r, busy_s;
   logic [31:0] mem_address_r, mem_address_s;
   logic [31:0] mem_wdata_r, mem_wdata_s;
   logic        mem_read_r, mem_read_s;
   logic        mem_write_r, mem_write_s;

   logic [1:0]  elig_s;
   logic [1:0]  set_done_s;
   logic        pick_s;
   logic        sel_we_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic [31:0] word_s;

   // Next-state, grant selection and next values of every registered output.
   always_comb begin
      state_s       = state_r;
      last_s        = last_r;
      gnt_s         = gnt_r;
      we_s          = we_r;
      ack_s         = 2'b00;
      err_s         = 2'b00;
      rdata0_s      = 32'd0;
      rdata1_s      = 32'd0;
      mem_address_s = 32'd0;
      mem_wdata_s   = 32'd0;
      mem_read_s    = 1'b0;
      mem_write_s   = 1'b0;
      set_done_s    = 2'b00;
      word_s        = 32'd0;

      elig_s      = {bus.req1, bus.req0} & ~done_r;
      pick_s      = (elig_s == 2'b11) ? ~last_r : elig_s[1];
      sel_we_s    = pick_s ? bus.we1    : bus.we0;
      sel_addr_s  = pick_s ? bus.addr1  : bus.addr0;
      sel_wdata_s = pick_s ? bus.wdata1 : bus.wdata0;

      case (state_r)
         IDLE: begin
            if (elig_s != 2'b00) begin
               gnt_s  = pick_s;
               last_s = pick_s;
               we_s   = sel_we_s;
               if (addr_legal(sel_addr_s)) begin
                  state_s       = ACCESS;
                  mem_address_s = sel_addr_s;
                  mem_wdata_s   = sel_wdata_s;
                  mem_read_s    = ~sel_we_s;
                  mem_write_s   = sel_we_s;
               end else begin
                  // Rejected: skip memory entirely and answer next cycle.
                  state_s        = RESP;
                  ack_s[pick_s]  = 1'b1;
                  err_s[pick_s]  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            state_s      = RESP;
            ack_s[gnt_r] = 1'b1;
            if (we_r) begin
               word_s = 32'd0;
            end else begin
               word_s = bus.mem_out;
            end
            if (gnt_r) begin
               rdata1_s = word_s;
            end else begin
               rdata0_s = word_s;
            end
         end
         RESP: begin
            state_s           = IDLE;
            set_done_s[gnt_r] = 1'b1;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // A dropped request always clears its done flag, even on the completing edge.
      done_s = {bus.req1, bus.req0} & (done_r | set_done_s);
      busy_s = (state_s != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         last_r        <= 1'b1;
         done_r        <= 2'b00;
         gnt_r         <= 1'b0;
         we_r          <= 1'b0;
         ack_r         <= 2'b00;
         err_r         <= 2'b00;
         rdata0_r      <= 32'd0;
         rdata1_r      <= 32'd0;
         busy_r        <= 1'b0;
         mem_address_r <= 32'd0;
         mem_wdata_r   <= 32'd0;
         mem_read_r    <= 1'b0;
         mem_write_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         last_r        <= last_s;
         done_r        <= done_s;
         gnt_r         <= gnt_s;
         we_r          <= we_s;
         ack_r         <= ack_s;
         err_r         <= err_s;
         rdata0_r      <= rdata0_s;
         rdata1_r      <= rdata1_s;
         busy_r        <= busy_s;
         mem_address_r <= mem_address_s;
         mem_wdata_r   <= mem_wdata_s;
         mem_read_r    <= mem_read_s;
         mem_write_r   <= mem_write_s;
      end
   end

   assign bus.ack0           = ack_r[0];
   assign bus.ack1           = ack_r[1];
   assign bus.err0           = err_r[0];
   assign bus.err1           = err_r[1];
   assign bus.rdata0         = rdata0_r;
   assign bus.rdata1         = rdata1_r;
   assign bus.busy           = busy_r;
   assign bus.mem_address    = mem_address_r;
   assign bus.mem_write_data = mem_wdata_r;
   assign bus.mem_read       = mem_read_r;
   assign bus.mem_write      = mem_write_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic scored
// against a transaction-level model of the 128-byte big-endian memory.
module tb_dmem_arbiter;
   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic mem_clear = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();
   dmem_arbiter #(.DEPTH(128)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [7:0] mem     [0:127];
   logic [7:0] ref_mem [0:127];
   int n_tests = 0, n_fail = 0, cyc = 0, mem_act = 0, both_ack = 0;

   // data_memory stand-in: negedge write, combinational read, junk when not reading.
   always @(negedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      end else if (bus.mem_write) begin
         mem[bus.mem_address[6:0]]         <= bus.mem_write_data[31:24];
         mem[bus.mem_address[6:0] + 7'd1] <= bus.mem_write_data[23:16];
         mem[bus.mem_address[6:0] + 7'd2] <= bus.mem_write_data[15:8];
         mem[bus.mem_address[6:0] + 7'd3] <= bus.mem_write_data[7:0];
      end
   end

   always_comb begin
      if (bus.mem_read) begin
         bus.mem_out = {mem[bus.mem_address[6:0]], mem[bus.mem_address[6:0] + 7'd1],
                        mem[bus.mem_address[6:0] + 7'd2], mem[bus.mem_address[6:0] + 7'd3]};
      end else begin
         bus.mem_out = 32'hA5A5_5A5A;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_read || bus.mem_write) mem_act++;
      if (bus.ack0 && bus.ack1) both_ack++;
   endtask

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= 32'd124);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return {ref_mem[a[6:0]], ref_mem[a[6:0] + 7'd1], ref_mem[a[6:0] + 7'd2], ref_mem[a[6:0] + 7'd3]};
   endfunction

   task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
      ref_mem[a[6:0]]         = d[31:24];
      ref_mem[a[6:0] + 7'd1] = d[23:16];
      ref_mem[a[6:0] + 7'd2] = d[15:8];
      ref_mem[a[6:0] + 7'd3] = d[7:0];
   endtask

   function automatic logic ack_of(input int p);
      return (p == 1) ? bus.ack1 : bus.ack0;
   endfunction

   task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (p == 1) begin
         bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
      end
   endtask

   // One complete 4-phase transaction on port p, checked against the model.
   task automatic do_txn(input string tag, input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int exp_lat);
      logic [31:0] exp_rd;
      int lat;
      exp_rd = (legal(a) && !w) ? ref_rd(a) : 32'd0;
      set_port(p, 1'b1, w, a, d);
      lat = 0;
      while (lat < 10 && !ack_of(p)) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " err"}, 32'((p == 1) ? bus.err1 : bus.err0), 32'(!legal(a)));
      check({tag, " rdata"}, (p == 1) ? bus.rdata1 : bus.rdata0, exp_rd);
      if (legal(a) && w) ref_wr(a, d);
      set_port(p, 1'b0, w, a, d);
      tick();
   endtask

   // Random-traffic per-port bookkeeping.
   logic        act  [2];
   int          st   [2];
   int          cool [2];
   logic        tw   [2];
   logic [31:0] ta   [2];
   logic [31:0] td   [2];

   initial begin
      int got, n, cnt0, n1, lat, mn;
      logic [31:0] a;
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);

      // Reset state
      tick(); tick();
      check("reset ctl", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy, bus.mem_read, bus.mem_write}), 32'd0);
      check("reset rdata0", bus.rdata0, 32'd0);
      check("reset rdata1", bus.rdata1, 32'd0);
      check("reset mem_address", bus.mem_address, 32'd0);
      check("reset mem_write_data", bus.mem_write_data, 32'd0);
      rst_n = 1'b1; mem_clear = 1'b0;
      tick();

      // Port 0 write then read at 8
      do_txn("p0 wr 8", 0, 1'b1, 32'd8, 32'hDEADBEEF, 2);
      check("mem[8..11]", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);
      do_txn("p0 rd 8", 0, 1'b0, 32'd8, 32'd0, 2);

      // Tie after reset alternates 0,1,0,1
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      set_port(0, 1'b1, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'd4, 32'd0);
      for (int k = 0; k < 4; k++) begin
         got = -1; n = 0;
         while (got < 0 && n < 8) begin
            tick(); n++;
            if (bus.ack0) got = 0;
            else if (bus.ack1) got = 1;
         end
         check($sformatf("rr order %0d", k), 32'(got), 32'(k % 2));
         if (got == 0) bus.req0 = 1'b0;
         if (got == 1) bus.req1 = 1'b0;
         tick();
         if (got == 0) bus.req0 = 1'b1;
         if (got == 1) bus.req1 = 1'b1;
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick(); tick(); tick(); tick();

      // Rejected accesses never touch memory
      mem_act = 0;
      do_txn("p1 rd 6", 1, 1'b0, 32'd6, 32'd0, 1);
      do_txn("p1 rd 128", 1, 1'b0, 32'd128, 32'd0, 1);
      do_txn("p1 wr FFFFFFFC", 1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1);
      check("reject mem strobes", 32'(mem_act), 32'd0);
      do_txn("p1 wr 124", 1, 1'b1, 32'd124, 32'hCAFE_F00D, 2);
      do_txn("p1 rd 124", 1, 1'b0, 32'd124, 32'd0, 2);

      // Held req0 is not re-granted; port 1 gets in at once
      set_port(0, 1'b1, 1'b0, 32'd8, 32'd0);
      tick(); tick();
      check("hold ack0", 32'(bus.ack0), 32'd1);
      set_port(1, 1'b1, 1'b0, 32'd12, 32'd0);
      cnt0 = 0; n1 = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.ack0) cnt0++;
         if (bus.ack1 && n1 < 0) begin
            n1 = i;
            check("hold rdata1", bus.rdata1, ref_rd(32'd12));
         end
      end
      check("hold extra ack0", 32'(cnt0), 32'd0);
      check("hold ack1 cycle", 32'(n1), 32'd3);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick();

      // Reset during ACCESS of a write at 124
      set_port(0, 1'b1, 1'b1, 32'd124, 32'h1122_3344);
      tick();
      check("rstacc mem_write", 32'(bus.mem_write), 32'd1);
      check("rstacc mem_address", bus.mem_address, 32'd124);
      rst_n = 1'b0; bus.req0 = 1'b0;
      tick();
      check("rstacc outs", 32'({bus.ack0, bus.err0, bus.busy, bus.mem_read, bus.mem_write}), 32'd0);
      check("rstacc addr", bus.mem_address, 32'd0);
      check("rstacc rdata0", bus.rdata0, 32'd0);
      check("rstacc mem[124]", {mem[124], mem[125], mem[126], mem[127]}, 32'h1122_3344);
      ref_wr(32'd124, 32'h1122_3344);
      rst_n = 1'b1;
      tick();
      check("rstacc no ack", 32'({bus.ack0, bus.ack1}), 32'd0);
      set_port(0, 1'b1, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'd4, 32'd0);
      got = -1; n = 0;
      while (got < 0 && n < 8) begin
         tick(); n++;
         if (bus.ack0) got = 0;
         else if (bus.ack1) got = 1;
      end
      check("last after reset", 32'(got), 32'd0);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick(); tick(); tick(); tick();

      // Changes after grant are ignored
      set_port(0, 1'b1, 1'b0, 32'd124, 32'd0);
      tick();
      check("late mem_address", bus.mem_address, 32'd124);
      check("late mem_read", 32'(bus.mem_read), 32'd1);
      set_port(0, 1'b0, 1'b1, 32'd8, 32'h0BAD_0BAD);
      tick();
      check("late ack0", 32'(bus.ack0), 32'd1);
      check("late rdata0", bus.rdata0, 32'h1122_3344);
      tick();
      check("late ack0 off", 32'(bus.ack0), 32'd0);
      check("late mem[8]", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);

      // Random two-port traffic
      for (int p = 0; p < 2; p++) begin
         act[p] = 1'b0; st[p] = 0; cool[p] = 1; tw[p] = 1'b0; ta[p] = 32'd0; td[p] = 32'd0;
      end
      for (int c = 0; c < 1500; c++) begin
         tick();
         if (bus.mem_read && bus.mem_write) check("rnd rd&wr", 32'd1, 32'd0);
         if (!bus.mem_read && !bus.mem_write) check("rnd idle addr", bus.mem_address, 32'd0);
         for (int p = 0; p < 2; p++) begin
            if (ack_of(p)) begin
               if (!act[p]) begin
                  check($sformatf("rnd p%0d spurious ack", p), 32'd1, 32'd0);
               end else begin
                  lat = cyc - st[p];
                  mn  = legal(ta[p]) ? 2 : 1;
                  check($sformatf("rnd p%0d latency %0d", p, lat), 32'(lat >= mn && lat <= 5), 32'd1);
                  check($sformatf("rnd p%0d err @%h", p, ta[p]),
                        32'((p == 1) ? bus.err1 : bus.err0), 32'(!legal(ta[p])));
                  check($sformatf("rnd p%0d rdata @%h", p, ta[p]), (p == 1) ? bus.rdata1 : bus.rdata0,
                        (legal(ta[p]) && !tw[p]) ? ref_rd(ta[p]) : 32'd0);
                  if (legal(ta[p]) && tw[p]) ref_wr(ta[p], td[p]);
               end
               act[p] = 1'b0;
               cool[p] = $urandom_range(1, 3);
               set_port(p, 1'b0, tw[p], ta[p], td[p]);
            end else if (act[p]) begin
               if (cyc - st[p] > 8) begin
                  check($sformatf("rnd p%0d timeout", p), 32'd1, 32'd0);
                  act[p] = 1'b0;
                  cool[p] = 1;
                  set_port(p, 1'b0, tw[p], ta[p], td[p]);
               end
            end else if (cool[p] > 0) begin
               cool[p]--;
            end else if ($urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 5))
                  0, 1:    a = 32'($urandom_range(0, 31)) << 2;
                  2:       a = 32'd124;
                  3:       a = 32'd128;
                  4:       a = 32'hFFFF_FFFC;
                  default: a = ($urandom & 32'h7F) | 32'd1;
               endcase
               act[p] = 1'b1; st[p] = cyc; tw[p] = 1'($urandom_range(0, 1)); ta[p] = a; td[p] = $urandom;
               set_port(p, 1'b1, tw[p], ta[p], td[p]);
            end
         end
      end
      check("never both acks", 32'(both_ack), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
